reset_sequencer: RTL and testbench

- Owns chip-level reset release ordering for NUM_DOM reset domains.
- Holds all domain resets for a minimum time, then releases each domain in index order (0 first).
- Each release follows a per-domain programmable delay. The next domain is not started until the current domain acknowledges ready or its ready timeout expires.
- Sits directly after the top-level reset synchronizer. Its o_rst_n outputs feed the per-domain reset synchronizers.

---
 rtl/reset_sequencer.sv | 153 +++++++++++++++
 tb/tb_reset_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Chip-level reset release sequencer: holds every domain in reset, then releases
// domains in index order, each after its own delay and a ready handshake (or timeout).
module reset_sequencer #(
  parameter int NUM_DOM  = 4,
  parameter int CNT_W    = 8,
  parameter int HOLD_CYC = 16,
  parameter int TMO_CYC  = 1024,
  localparam int IDX_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sw_rst_req,
  input  logic [NUM_DOM*CNT_W-1:0] i_dly,
  input  logic [NUM_DOM-1:0]       i_dom_ready,
  output logic [NUM_DOM-1:0]       o_rst_n,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic [IDX_W-1:0]         o_err_dom
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int TMO_W  = $clog2(TMO_CYC + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    HOLD,
    DELAY,
    WAIT_RDY,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    dly_q, dly_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [NUM_DOM-1:0]  rst_n_q, rst_n_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_dom_q, err_dom_d;
  logic                advance;

  logic [CNT_W-1:0] dly_field [NUM_DOM];

  for (genvar k = 0; k < NUM_DOM; k++) begin : g_dly_field
    assign dly_field[k] = i_dly[k*CNT_W +: CNT_W];
  end

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    dly_d     = dly_q;
    tmo_d     = tmo_q;
    rst_n_d   = rst_n_q;
    err_d     = err_q;
    err_dom_d = err_dom_q;
    advance   = 1'b0;

    case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = DELAY;
          idx_d   = '0;
          hold_d  = '0;
          dly_d   = dly_field[0];
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      DELAY: begin
        if (dly_q == '0) begin
          rst_n_d[idx_q] = 1'b1;
          tmo_d          = '0;
          state_d        = WAIT_RDY;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
      WAIT_RDY: begin
        // Ready is checked first so a same-edge ready beats the timeout.
        if (i_dom_ready[idx_q]) begin
          advance = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          advance = 1'b1;
          err_d   = 1'b1;
          if (!err_q) err_dom_d = idx_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (advance) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_nxt;
            dly_d   = dly_field[idx_nxt];
            state_d = DELAY;
          end
        end
      end
      DONE: ;
      default: state_d = HOLD;
    endcase

    // A software request aborts whatever is in flight and restarts the full hold.
    if (i_sw_rst_req) begin
      state_d   = HOLD;
      idx_d     = '0;
      hold_d    = '0;
      dly_d     = '0;
      tmo_d     = '0;
      rst_n_d   = '0;
      err_d     = 1'b0;
      err_dom_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= HOLD;
      idx_q     <= '0;
      hold_q    <= '0;
      dly_q     <= '0;
      tmo_q     <= '0;
      rst_n_q   <= '0;
      err_q     <= 1'b0;
      err_dom_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      dly_q     <= dly_d;
      tmo_q     <= tmo_d;
      rst_n_q   <= rst_n_d;
      err_q     <= err_d;
      err_dom_q <= err_dom_d;
    end
  end

  assign o_rst_n   = rst_n_q;
  assign o_busy    = (state_q != DONE);
  assign o_done    = (state_q == DONE);
  assign o_err     = err_q;
  assign o_err_dom = err_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each planned sequence queues its expected
// release/done edges; a negedge monitor pops and compares them as they occur.
module tb_reset_sequencer;

  localparam int NUM_DOM  = 4;
  localparam int CNT_W    = 8;
  localparam int HOLD_CYC = 16;
  localparam int TMO_CYC  = 1024;
  localparam int IDX_W    = 2;

  typedef struct {
    int dom;
    int cyc;
  } ev_t;

  logic                     clk = 1'b0;
  logic                     i_rst = 1'b1;
  logic                     i_sw_rst_req = 1'b0;
  logic [NUM_DOM*CNT_W-1:0] dly_bus = '0;
  logic [NUM_DOM-1:0]       ready = '0;
  logic [NUM_DOM-1:0]       o_rst_n;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_err;
  logic [IDX_W-1:0]         o_err_dom;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ev_t exp_q[$];
  int  lat[NUM_DOM];
  int  rel_cyc[NUM_DOM];
  int  exp_err = 0;
  int  exp_err_dom = 0;
  logic kill = 1'b0;
  logic [NUM_DOM-1:0] prev_rst = '0;
  logic prev_done = 1'b0;

  reset_sequencer #(
    .NUM_DOM (NUM_DOM),
    .CNT_W   (CNT_W),
    .HOLD_CYC(HOLD_CYC),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_sw_rst_req(i_sw_rst_req),
    .i_dly       (dly_bus),
    .i_dom_ready (ready),
    .o_rst_n     (o_rst_n),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_err_dom   (o_err_dom)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic note_event(input int dom);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", dom, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_dom", dom, e.dom);
      check("event_cyc", cyc, e.cyc);
    end
  endtask

  // Monitor and ready responder: a domain answers lat[k] cycles after its release,
  // lat < 0 means it never answers.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_DOM; k++) begin
      if (o_rst_n[k] === 1'b1 && !prev_rst[k]) begin
        rel_cyc[k] = cyc;
        note_event(k);
      end
    end
    if (o_done === 1'b1 && !prev_done) note_event(NUM_DOM);
    prev_rst  = o_rst_n;
    prev_done = (o_done === 1'b1);
    for (int k = 0; k < NUM_DOM; k++)
      ready[k] = (o_rst_n[k] === 1'b1) && !kill && (lat[k] >= 0) && (cyc - rel_cyc[k] >= lat[k]);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_dly(input int d);
    for (int k = 0; k < NUM_DOM; k++) dly_bus[k*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  // t0 is the last edge at which i_rst or i_sw_rst_req was sampled high.
  task automatic plan(input int t0);
    int t;
    int rel;
    int d;
    t = t0 + HOLD_CYC;
    exp_err = 0;
    exp_err_dom = 0;
    for (int k = 0; k < NUM_DOM; k++) begin
      d   = int'(dly_bus[k*CNT_W +: CNT_W]);
      rel = t + d + 1;
      exp_q.push_back('{dom: k, cyc: rel});
      if (lat[k] >= 0 && lat[k] <= TMO_CYC - 1) begin
        t = rel + 1 + lat[k];
      end else begin
        t = rel + TMO_CYC;
        if (exp_err == 0) begin
          exp_err = 1;
          exp_err_dom = k;
        end
      end
    end
    exp_q.push_back('{dom: NUM_DOM, cyc: t});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rst_n"}, o_rst_n, 0);
    check({tag, "_busy"}, o_busy, 1);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_err_dom"}, o_err_dom, 0);
  endtask

  task automatic apply_reset(input string tag);
    i_rst = 1'b1;
    i_sw_rst_req = 1'b0;
    repeat (3) tick();
    check_reset_state(tag);
    exp_q.delete();
    i_rst = 1'b0;
    plan(cyc);
  endtask

  task automatic run_to_done(input string tag);
    for (int i = 0; i < 8000 && exp_q.size() != 0; i++) tick();
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_done"}, o_done, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_rst_n"}, o_rst_n, 4'hF);
    check({tag, "_err"}, o_err, exp_err);
    check({tag, "_err_dom"}, o_err_dom, exp_err_dom);
  endtask

  initial begin
    lat = '{0, 0, 0, 0};
    rel_cyc = '{0, 0, 0, 0};

    // Baseline: delay 4 everywhere, immediate ready; ready drops in DONE are ignored.
    set_dly(4);
    apply_reset("s1");
    run_to_done("s1");
    kill = 1'b1;
    repeat (5) tick();
    check("s1_done_hold", o_done, 1);
    check("s1_rst_hold", o_rst_n, 4'hF);
    kill = 1'b0;

    // Zero delays, domain 2 answers three cycles late.
    set_dly(0);
    lat = '{0, 0, 3, 0};
    apply_reset("s2");
    run_to_done("s2");

    // Domain 1 never answers.
    set_dly(4);
    lat = '{0, -1, 0, 0};
    apply_reset("s3");
    run_to_done("s3");

    // Domains 1 and 3 time out; only the first is recorded. Then a request in DONE.
    lat = '{0, -1, 0, -1};
    apply_reset("s4");
    run_to_done("s4");
    i_sw_rst_req = 1'b1;
    tick();
    check_reset_state("s4_req");
    i_sw_rst_req = 1'b0;

    // Timeout boundary: ready on the last allowed edge wins, one edge later loses.
    lat = '{TMO_CYC - 1, 0, 0, TMO_CYC};
    apply_reset("s5");
    run_to_done("s5");

    // Software request while waiting on a slow domain 1, then a clean rerun.
    lat = '{0, 50, 0, 0};
    apply_reset("s6");
    for (int i = 0; i < 300 && o_rst_n != 4'b0011; i++) tick();
    check("s6_reach_0011", o_rst_n, 4'b0011);
    repeat (5) tick();
    exp_q.delete();
    i_sw_rst_req = 1'b1;
    tick();
    check_reset_state("s6_req");
    i_sw_rst_req = 1'b0;
    plan(cyc);
    run_to_done("s6");

    // i_rst together with a request mid-DELAY, then a full rerun; a field change
    // after DELAY entry must not affect the running count.
    set_dly(20);
    lat = '{0, 0, 0, 0};
    apply_reset("s7a");
    repeat (HOLD_CYC + 5) tick();
    check("s7_mid_delay", o_rst_n, 0);
    exp_q.delete();
    i_rst = 1'b1;
    i_sw_rst_req = 1'b1;
    tick();
    check_reset_state("s7_rst");
    i_rst = 1'b0;
    i_sw_rst_req = 1'b0;
    plan(cyc);
    repeat (HOLD_CYC + 3) tick();
    dly_bus[0 +: CNT_W] = CNT_W'(1);
    run_to_done("s7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
